// File: rtl/memory_access_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_if
// Description : Data-memory request/response bundle between the memory-access
//               stage (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_access_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [63:0] dmem_addr;
    logic        dmem_we;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_rsp_valid;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_req_valid,
        output dmem_addr,
        output dmem_we,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_req_ready,
        input  dmem_rsp_valid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req_valid,
        input  dmem_addr,
        input  dmem_we,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_req_ready,
        output dmem_rsp_valid,
        output dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/memory_access.sv
`default_nettype none
// ============================================================================
// Module      : memory_access
// Description : Pipeline memory-access stage. Pass-through for non-memory and
//               misaligned instructions; issues one aligned 64-bit dmem request
//               per load/store, extracts/extends load data, and presents a
//               registered writeback bundle that honours writeback stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_access (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [4:0]            in_rd,
    input  logic [63:0]           in_result,
    input  logic                  in_write_to_rd,
    input  logic                  in_is_branch_addr,
    input  logic [63:0]           in_op2,
    input  logic                  in_is_mem,
    input  logic                  in_is_write,
    input  logic                  in_is_final,
    input  logic [2:0]            in_lsv,
    input  logic                  stall_in,
    output logic                  stall_out,
    memory_access_if.master       dmem,
    output logic                  wb_valid_q,
    output logic [4:0]            wb_rd_q,
    output logic [63:0]           wb_data_q,
    output logic                  wb_write_to_rd_q,
    output logic                  wb_is_branch_addr_q,
    output logic                  wb_is_final_q,
    output logic                  wb_misaligned_q
);

    // load_store_variant_e encoding
    localparam logic [2:0] c_lsv_b  = 3'd0;
    localparam logic [2:0] c_lsv_h  = 3'd1;
    localparam logic [2:0] c_lsv_w  = 3'd2;
    localparam logic [2:0] c_lsv_d  = 3'd3;
    localparam logic [2:0] c_lsv_bu = 3'd4;
    localparam logic [2:0] c_lsv_hu = 3'd5;
    localparam logic [2:0] c_lsv_wu = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_req_valid;
    logic [63:0] r_result;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;
    logic        r_is_write;
    logic [2:0]  r_lsv;
    logic [4:0]  r_rd;
    logic        r_write_to_rd;
    logic        r_is_branch_addr;
    logic        r_is_final;
    logic [63:0] r_hold_data;

    logic [2:0]  w_align_mask;
    logic [7:0]  w_byte_mask;
    logic        w_misaligned;
    logic        w_accept;
    logic [63:0] w_shifted;
    logic [63:0] w_load_data;
    logic        w_finish;
    logic [63:0] w_finish_data;

    assign stall_out           = stall_in | (r_state != ST_IDLE);
    assign dmem.dmem_req_valid = r_req_valid;
    assign dmem.dmem_addr      = {r_result[63:3], 3'b000};
    assign dmem.dmem_we        = r_is_write;
    assign dmem.dmem_wdata     = r_wdata;
    assign dmem.dmem_wstrb     = r_wstrb;
    assign w_accept            = (r_state == ST_IDLE) & in_valid & ~stall_in;

    // Access size of the incoming instruction: alignment check and lane mask
    always_comb begin
        w_align_mask = 3'b111;
        w_byte_mask  = 8'hFF;
        case (in_lsv)
            c_lsv_b, c_lsv_bu: begin w_align_mask = 3'b000; w_byte_mask = 8'h01; end
            c_lsv_h, c_lsv_hu: begin w_align_mask = 3'b001; w_byte_mask = 8'h03; end
            c_lsv_w, c_lsv_wu: begin w_align_mask = 3'b011; w_byte_mask = 8'h0F; end
            default:           begin w_align_mask = 3'b111; w_byte_mask = 8'hFF; end
        endcase
        w_misaligned = |(in_result[2:0] & w_align_mask);
    end

    // Pull the addressed lanes down to bit 0 and sign/zero extend to 64 bits
    always_comb begin
        w_shifted = dmem.dmem_rdata >> {r_result[2:0], 3'b000};
        case (r_lsv)
            c_lsv_b:  w_load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            c_lsv_h:  w_load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            c_lsv_w:  w_load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            c_lsv_bu: w_load_data = {56'd0, w_shifted[7:0]};
            c_lsv_hu: w_load_data = {48'd0, w_shifted[15:0]};
            c_lsv_wu: w_load_data = {32'd0, w_shifted[31:0]};
            default:  w_load_data = w_shifted;
        endcase
    end

    // A memory transaction completes into writeback this cycle
    always_comb begin
        w_finish      = 1'b0;
        w_finish_data = r_hold_data;
        case (r_state)
            ST_REQ: begin
                w_finish      = dmem.dmem_req_ready & r_is_write & ~stall_in;
                w_finish_data = r_result;
            end
            ST_WAIT_RSP: begin
                w_finish      = dmem.dmem_rsp_valid & ~stall_in;
                w_finish_data = w_load_data;
            end
            ST_HOLD: begin
                w_finish      = ~stall_in;
                w_finish_data = r_hold_data;
            end
            default: begin
                w_finish      = 1'b0;
                w_finish_data = r_hold_data;
            end
        endcase
    end

    // Transaction FSM, request registers and writeback bundle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state             <= ST_IDLE;
            r_req_valid         <= 1'b0;
            r_result            <= 64'd0;
            r_wdata             <= 64'd0;
            r_wstrb             <= 8'd0;
            r_is_write          <= 1'b0;
            r_lsv               <= 3'd0;
            r_rd                <= 5'd0;
            r_write_to_rd       <= 1'b0;
            r_is_branch_addr    <= 1'b0;
            r_is_final          <= 1'b0;
            r_hold_data         <= 64'd0;
            wb_valid_q          <= 1'b0;
            wb_rd_q             <= 5'd0;
            wb_data_q           <= 64'd0;
            wb_write_to_rd_q    <= 1'b0;
            wb_is_branch_addr_q <= 1'b0;
            wb_is_final_q       <= 1'b0;
            wb_misaligned_q     <= 1'b0;
        end else begin
            // Writeback free and nothing completing: emit a bubble
            if (!stall_in) begin
                wb_valid_q <= 1'b0;
            end

            if (w_finish) begin
                wb_valid_q          <= 1'b1;
                wb_rd_q             <= r_rd;
                wb_data_q           <= w_finish_data;
                wb_write_to_rd_q    <= r_write_to_rd & ~r_is_write;
                wb_is_branch_addr_q <= r_is_branch_addr;
                wb_is_final_q       <= r_is_final;
                wb_misaligned_q     <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_result         <= in_result;
                        r_wdata          <= in_op2 << {in_result[2:0], 3'b000};
                        r_wstrb          <= w_byte_mask << in_result[2:0];
                        r_is_write       <= in_is_write;
                        r_lsv            <= in_lsv;
                        r_rd             <= in_rd;
                        r_write_to_rd    <= in_write_to_rd;
                        r_is_branch_addr <= in_is_branch_addr;
                        r_is_final       <= in_is_final;
                        if (!in_is_mem || w_misaligned) begin
                            // Single-cycle path; a misaligned access never reaches dmem
                            wb_valid_q          <= 1'b1;
                            wb_rd_q             <= in_rd;
                            wb_data_q           <= in_result;
                            wb_write_to_rd_q    <= in_write_to_rd & ~(in_is_mem & w_misaligned);
                            wb_is_branch_addr_q <= in_is_branch_addr;
                            wb_is_final_q       <= in_is_final;
                            wb_misaligned_q     <= in_is_mem & w_misaligned;
                        end else begin
                            r_state     <= ST_REQ;
                            r_req_valid <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem.dmem_req_ready) begin
                        r_req_valid <= 1'b0;
                        if (!r_is_write) begin
                            r_state <= ST_WAIT_RSP;
                        end else if (!stall_in) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_hold_data <= r_result;
                            r_state     <= ST_HOLD;
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (dmem.dmem_rsp_valid) begin
                        if (!stall_in) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_hold_data <= w_load_data;
                            r_state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall_in) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access
// Description : Directed self-checking bench for memory_access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  in_rd;
    logic [63:0] in_result;
    logic        in_write_to_rd;
    logic        in_is_branch_addr;
    logic [63:0] in_op2;
    logic        in_is_mem;
    logic        in_is_write;
    logic        in_is_final;
    logic [2:0]  in_lsv;
    logic        stall_in;
    logic        stall_out;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [63:0] wb_data_q;
    logic        wb_write_to_rd_q;
    logic        wb_is_branch_addr_q;
    logic        wb_is_final_q;
    logic        wb_misaligned_q;

    int n_checks = 0;
    int n_pass   = 0;

    memory_access_if dmem ();

    memory_access u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_valid            (in_valid),
        .in_rd               (in_rd),
        .in_result           (in_result),
        .in_write_to_rd      (in_write_to_rd),
        .in_is_branch_addr   (in_is_branch_addr),
        .in_op2              (in_op2),
        .in_is_mem           (in_is_mem),
        .in_is_write         (in_is_write),
        .in_is_final         (in_is_final),
        .in_lsv              (in_lsv),
        .stall_in            (stall_in),
        .stall_out           (stall_out),
        .dmem                (dmem.master),
        .wb_valid_q          (wb_valid_q),
        .wb_rd_q             (wb_rd_q),
        .wb_data_q           (wb_data_q),
        .wb_write_to_rd_q    (wb_write_to_rd_q),
        .wb_is_branch_addr_q (wb_is_branch_addr_q),
        .wb_is_final_q       (wb_is_final_q),
        .wb_misaligned_q     (wb_misaligned_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic is_mem, input logic is_write, input logic [2:0] lsv,
                         input logic [63:0] result, input logic [63:0] op2, input logic [4:0] rd,
                         input logic wtr, input logic branch, input logic fin);
        in_valid          = 1'b1;
        in_is_mem         = is_mem;
        in_is_write       = is_write;
        in_lsv            = lsv;
        in_result         = result;
        in_op2            = op2;
        in_rd             = rd;
        in_write_to_rd    = wtr;
        in_is_branch_addr = branch;
        in_is_final       = fin;
        tick();
        in_valid          = 1'b0;
    endtask

    // Aligned load with immediate ready and response on the following cycle
    task automatic run_load(input logic [2:0] lsv, input logic [63:0] addr,
                            input logic [63:0] rdata, input logic [4:0] rd);
        issue(1'b1, 1'b0, lsv, addr, 64'd0, rd, 1'b1, 1'b0, 1'b0);
        dmem.dmem_req_ready = 1'b1;
        tick();
        dmem.dmem_req_ready = 1'b0;
        dmem.dmem_rsp_valid = 1'b1;
        dmem.dmem_rdata     = rdata;
        tick();
        dmem.dmem_rsp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_rd = '0; in_result = '0; in_write_to_rd = 1'b0;
        in_is_branch_addr = 1'b0; in_op2 = '0; in_is_mem = 1'b0; in_is_write = 1'b0;
        in_is_final = 1'b0; in_lsv = '0; stall_in = 1'b0;
        dmem.dmem_req_ready = 1'b0; dmem.dmem_rsp_valid = 1'b0; dmem.dmem_rdata = '0;
        tick();
        tick();
        check("rst_wb_valid", 64'(wb_valid_q), 64'd0);
        check("rst_wb_data", wb_data_q, 64'd0);
        check("rst_req_valid", 64'(dmem.dmem_req_valid), 64'd0);
        check("rst_stall_out", 64'(stall_out), 64'd0);
        rst_n = 1'b1;
        tick();

        // ALU result passes straight through with one cycle latency
        issue(1'b0, 1'b0, 3'd3, 64'h1234, 64'd0, 5'd5, 1'b1, 1'b1, 1'b1);
        check("add_wb_valid", 64'(wb_valid_q), 64'd1);
        check("add_wb_data", wb_data_q, 64'h1234);
        check("add_wb_rd", 64'(wb_rd_q), 64'd5);
        check("add_wb_wtr", 64'(wb_write_to_rd_q), 64'd1);
        check("add_branch", 64'(wb_is_branch_addr_q), 64'd1);
        check("add_final", 64'(wb_is_final_q), 64'd1);
        check("add_no_req", 64'(dmem.dmem_req_valid), 64'd0);
        tick();
        check("add_bubble", 64'(wb_valid_q), 64'd0);

        // LB at 0x1003, ready held low for two cycles
        issue(1'b1, 1'b0, 3'd0, 64'h1003, 64'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        check("lb_req_valid", 64'(dmem.dmem_req_valid), 64'd1);
        check("lb_addr", dmem.dmem_addr, 64'h1000);
        check("lb_we", 64'(dmem.dmem_we), 64'd0);
        check("lb_stall_out", 64'(stall_out), 64'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("lb_req_hold", 64'(dmem.dmem_req_valid), 64'd1);
            check("lb_addr_hold", dmem.dmem_addr, 64'h1000);
        end
        dmem.dmem_req_ready = 1'b1;
        tick();
        dmem.dmem_req_ready = 1'b0;
        check("lb_req_drop", 64'(dmem.dmem_req_valid), 64'd0);
        check("lb_wait_valid", 64'(wb_valid_q), 64'd0);
        dmem.dmem_rsp_valid = 1'b1;
        dmem.dmem_rdata     = 64'h00000000_80000000;
        tick();
        dmem.dmem_rsp_valid = 1'b0;
        check("lb_wb_valid", 64'(wb_valid_q), 64'd1);
        check("lb_wb_data", wb_data_q, 64'hFFFFFFFF_FFFFFF80);
        check("lb_wb_rd", 64'(wb_rd_q), 64'd7);
        check("lb_stall_out", 64'(stall_out), 64'd0);

        run_load(3'd4, 64'h1003, 64'h00000000_80000000, 5'd8);
        check("lbu_wb_data", wb_data_q, 64'h80);
        check("lbu_wb_wtr", 64'(wb_write_to_rd_q), 64'd1);

        // SH at 0x2006
        issue(1'b1, 1'b1, 3'd1, 64'h2006, 64'hBEEF, 5'd3, 1'b1, 1'b0, 1'b0);
        check("sh_wstrb", 64'(dmem.dmem_wstrb), 64'hC0);
        check("sh_wdata", dmem.dmem_wdata, 64'hBEEF0000_00000000);
        check("sh_we", 64'(dmem.dmem_we), 64'd1);
        check("sh_addr", dmem.dmem_addr, 64'h2000);
        dmem.dmem_req_ready = 1'b1;
        tick();
        dmem.dmem_req_ready = 1'b0;
        check("sh_wb_valid", 64'(wb_valid_q), 64'd1);
        check("sh_wb_wtr", 64'(wb_write_to_rd_q), 64'd0);
        check("sh_stall_out", 64'(stall_out), 64'd0);

        // Misaligned LW at 0x3002
        issue(1'b1, 1'b0, 3'd2, 64'h3002, 64'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        check("lwm_no_req", 64'(dmem.dmem_req_valid), 64'd0);
        check("lwm_wb_valid", 64'(wb_valid_q), 64'd1);
        check("lwm_misaligned", 64'(wb_misaligned_q), 64'd1);
        check("lwm_wb_wtr", 64'(wb_write_to_rd_q), 64'd0);
        check("lwm_wb_data", wb_data_q, 64'h3002);
        check("lwm_stall_out", 64'(stall_out), 64'd0);

        // Word and half-word extension
        run_load(3'd2, 64'h5004, 64'h80000001_00000000, 5'd10);
        check("lw_wb_data", wb_data_q, 64'hFFFFFFFF_80000001);
        check("lw_misaligned_clr", 64'(wb_misaligned_q), 64'd0);
        run_load(3'd6, 64'h5004, 64'h80000001_00000000, 5'd10);
        check("lwu_wb_data", wb_data_q, 64'h00000000_80000001);
        run_load(3'd1, 64'h6002, 64'h00000000_87650000, 5'd11);
        check("lh_wb_data", wb_data_q, 64'hFFFFFFFF_FFFF8765);

        // Writeback stall holds a completed bundle
        issue(1'b0, 1'b0, 3'd0, 64'h55, 64'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        stall_in = 1'b1;
        tick();
        check("stall_hold_valid", 64'(wb_valid_q), 64'd1);
        check("stall_hold_data", wb_data_q, 64'h55);
        check("stall_out_in", 64'(stall_out), 64'd1);
        stall_in = 1'b0;
        tick();
        check("stall_release_bubble", 64'(wb_valid_q), 64'd0);

        // LD response arrives while writeback stalls for three cycles
        issue(1'b1, 1'b0, 3'd3, 64'h4008, 64'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        dmem.dmem_req_ready = 1'b1;
        tick();
        dmem.dmem_req_ready = 1'b0;
        stall_in = 1'b1;
        dmem.dmem_rsp_valid = 1'b1;
        dmem.dmem_rdata     = 64'h11223344_55667788;
        tick();
        dmem.dmem_rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("ld_hold_stall_out", 64'(stall_out), 64'd1);
            check("ld_hold_valid", 64'(wb_valid_q), 64'd0);
            tick();
        end
        stall_in = 1'b0;
        check("ld_hold_state_stall", 64'(stall_out), 64'd1);
        check("ld_hold_no_data", 64'(wb_valid_q), 64'd0);
        tick();
        check("ld_wb_valid", 64'(wb_valid_q), 64'd1);
        check("ld_wb_data", wb_data_q, 64'h11223344_55667788);
        check("ld_wb_rd", 64'(wb_rd_q), 64'd9);
        check("ld_stall_out", 64'(stall_out), 64'd0);

        // Reset while waiting for a load response; late response ignored
        issue(1'b1, 1'b0, 3'd2, 64'h5004, 64'd0, 5'd12, 1'b1, 1'b0, 1'b0);
        dmem.dmem_req_ready = 1'b1;
        tick();
        dmem.dmem_req_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstw_stall_out", 64'(stall_out), 64'd0);
        check("rstw_wb_valid", 64'(wb_valid_q), 64'd0);
        check("rstw_req_valid", 64'(dmem.dmem_req_valid), 64'd0);
        dmem.dmem_rsp_valid = 1'b1;
        dmem.dmem_rdata     = 64'hDEADBEEF_CAFEF00D;
        tick();
        dmem.dmem_rsp_valid = 1'b0;
        check("late_rsp_wb_valid", 64'(wb_valid_q), 64'd0);
        check("late_rsp_wb_data", wb_data_q, 64'd0);
        check("late_rsp_stall_out", 64'(stall_out), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 in_valid  in  1  execute latched result valid.
REQ-004 in_rd  in  5  destination register.
REQ-005 in_result  in  64  ALU result; byte address when in_is_mem=1.
REQ-006 in_write_to_rd  in  1  instruction writes rd.
REQ-007 in_is_branch_addr  in  1  in_result is a taken-branch target; pass-through only.
REQ-008 in_op2  in  64  store data.
REQ-009 in_is_mem / in_is_write  in  1/1  memory access / access is a store.
REQ-010 in_is_final  in  1  final-instruction marker.
REQ-011 in_lsv  in  3  load_store_variant_e: 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU.
REQ-012 stall_in  in  1  writeback cannot accept.
REQ-013 stall_out  out  1  holds execute latch.
REQ-014 dmem_req_valid / dmem_req_ready  out/in  1/1  request handshake.
REQ-015 dmem_addr  out  64  in_result with bits [2:0] cleared.
REQ-016 dmem_we  out  1  1 = store.
REQ-017 dmem_wdata / dmem_wstrb  out  64/8  lane-aligned store data / byte enables.
REQ-018 dmem_rsp_valid / dmem_rdata  in  1/64  load response; one-cycle pulse, exactly one per accepted load request.
REQ-019 wb_valid_q, wb_rd_q[4:0], wb_data_q[63:0], wb_write_to_rd_q, wb_is_branch_addr_q, wb_is_final_q, wb_misaligned_q  out  registered writeback bundle.

Function
REQ-020 FSM states IDLE, REQ, WAIT_RSP, HOLD; stall_out = stall_in OR state!=IDLE.
REQ-021 Accept: IDLE and in_valid and !stall_in; in_* fields captured at that edge.
REQ-022 Size from in_lsv: 1/2/4/8 bytes; misaligned when in_result mod size != 0.
REQ-023 Non-memory or misaligned accept: no dmem request; wb bundle loads at same edge (1-cycle latency); wb_data_q=in_result; misaligned forces wb_write_to_rd_q=0, wb_misaligned_q=1.
REQ-024 Aligned memory accept -> REQ; dmem_req_valid=1 only in REQ; addr/we/wdata/wstrb stable while in REQ.
REQ-025 wdata = in_op2 << 8*addr[2:0]; wstrb = (2^size-1) << addr[2:0].
REQ-026 REQ with ready: store -> IDLE completing (wb_write_to_rd_q=0) if !stall_in, else HOLD; load -> WAIT_RSP.
REQ-027 WAIT_RSP with dmem_rsp_valid: data = dmem_rdata >> 8*addr[2:0], truncated to size, sign-extended (B/H/W) or zero-extended (BU/HU/WU/D); -> IDLE completing if !stall_in, else HOLD capturing data.
REQ-028 HOLD: leaves to IDLE, completing with held data, on first cycle !stall_in.
REQ-029 Completion: wb_valid_q=1 and wb bundle loaded; any other cycle with !stall_in loads wb_valid_q=0 (bubble); stall_in=1 holds the whole bundle.
REQ-030 wb_is_branch_addr_q, wb_is_final_q, wb_rd_q copy captured inputs; wb_misaligned_q=0 except REQ-023.
REQ-031 dmem_rsp_valid outside WAIT_RSP ignored.

Reset
REQ-032 rst_n=0 at edge: state IDLE, dmem_req_valid=0, wb_valid_q=0, all other wb_* =0, mid-transaction request abandoned, late response ignored per REQ-031.

Verification
REQ-033 ADD result 0x1234, rd=5, no stalls -> next edge wb_valid_q=1, wb_data_q=0x1234, wb_rd_q=5.
REQ-034 LB addr 0x1003, rdata 0x00000000_80000000 after ready held low 2 cycles -> dmem_addr 0x1000, wb_data_q=0xFFFFFFFF_FFFFFF80; LBU -> 0x80.
REQ-035 SH addr 0x2006, op2 0xBEEF -> wstrb 0xC0, wdata 0xBEEF0000_00000000, wb_write_to_rd_q=0.
REQ-036 LW addr 0x3002 -> no request, wb_misaligned_q=1, wb_write_to_rd_q=0.
REQ-037 LD response while stall_in=1 for 3 cycles -> HOLD, stall_out=1 throughout, wb_data_q updates on first cycle stall_in=0.
REQ-038 rst_n low in WAIT_RSP, response arrives next cycle -> state IDLE, wb_valid_q stays 0.
